seq_mult_hs: RTL and testbench

//  Parametrised shift-add sequential multiplier with valid/ready handshakes
//  on input and output. Supports unsigned and two's-complement operands.

---
 rtl/seq_mult_pkg.sv | 10 +
 rtl/seq_mult_dp.sv | 52 +++++
 rtl/seq_mult_hs.sv | 99 +++++++++
 tb/tb_seq_mult_hs.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the seq_mult_hs shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_mult_state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Shift-add datapath: multiplier shifter, extended multiplicand shifter and
// modulo-2^PW accumulator. The sub control turns the add into a subtract.
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8,
  parameter int SIGNED  = 0
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       load,
  input  logic                       step,
  input  logic                       sub,
  input  logic [WIDTH_A-1:0]         in_a,
  input  logic [WIDTH_B-1:0]         in_b,
  output logic                       a_zero,
  output logic [WIDTH_A+WIDTH_B-1:0] acc
);

  localparam int PW = WIDTH_A + WIDTH_B;

  logic [WIDTH_A-1:0] a_sh;
  logic [PW-1:0]      b_sh;
  logic [PW-1:0]      b_ext;
  logic [PW-1:0]      acc_q;

  always_comb begin
    if (SIGNED != 0) b_ext = {{WIDTH_A{in_b[WIDTH_B-1]}}, in_b};
    else             b_ext = {{WIDTH_A{1'b0}}, in_b};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc_q <= '0;
    end else if (load) begin
      a_sh  <= in_a;
      b_sh  <= b_ext;
      acc_q <= '0;
    end else if (step) begin
      if (a_sh[0]) acc_q <= sub ? (acc_q - b_sh) : (acc_q + b_sh);
      a_sh <= a_sh >> 1;
      b_sh <= b_sh << 1;
    end
  end

  assign a_zero = (a_sh == '0);
  assign acc    = acc_q;

endmodule

// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier with valid/ready handshakes, one multiplier
// bit per clock. Define SEQ_MULT_EARLY_TERM_EN to finish once a_sh runs out.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | consuming one multiplier bit per clock, busy high
//   DONE  | product held on out_prod until out_ready
module seq_mult_hs
  import seq_mult_pkg::*;
#(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8,
  parameter int SIGNED  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         in_a,
  input  logic [WIDTH_B-1:0]         in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] out_prod,
  output logic                       busy
);

  localparam int CW = cnt_w(WIDTH_A);
  localparam logic [CW-1:0] LAST = CW'(WIDTH_A - 1);
`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  seq_mult_state_t state, state_nxt;
  logic [CW-1:0]   count;
  logic            load, step, sub, a_zero;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (load) count <= '0;
    else if (step) count <= count + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    sub       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Remaining multiplier bits all zero: the accumulator is already final.
        if (EARLY_TERM && a_zero) begin
          state_nxt = DONE;
        end else begin
          step = 1'b1;
          sub  = (SIGNED != 0) && (count == LAST);
          if (count == LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  seq_mult_dp #(
    .WIDTH_A(WIDTH_A),
    .WIDTH_B(WIDTH_B),
    .SIGNED (SIGNED)
  ) u_dp (
    .clk   (clk),
    .clr   (rst),
    .load  (load),
    .step  (step),
    .sub   (sub),
    .in_a  (in_a),
    .in_b  (in_b),
    .a_zero(a_zero),
    .acc   (out_prod)
  );

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed and random checks of seq_mult_hs in three configurations:
// 8x8 unsigned, 8x8 signed and 12x4 unsigned.
module tb_seq_mult_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_ready = 1'b1;

  logic        iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
  logic [7:0]  a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [11:0] a2 = '0;
  logic [3:0]  b2 = '0;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
  logic [15:0] p0, p1;
  logic [15:0] p2;
  logic [23:0] p2w;

  int cur = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic        s_ir, s_ov, s_bz;
  logic [23:0] s_prod;

  always #5 clk = ~clk;

  seq_mult_hs #(.WIDTH_A(8), .WIDTH_B(8), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_a(a0), .in_b(b0),
    .out_valid(ov0), .out_ready(out_ready), .out_prod(p0), .busy(bz0));

  seq_mult_hs #(.WIDTH_A(8), .WIDTH_B(8), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_a(a1), .in_b(b1),
    .out_valid(ov1), .out_ready(out_ready), .out_prod(p1), .busy(bz1));

  seq_mult_hs #(.WIDTH_A(12), .WIDTH_B(4), .SIGNED(0)) u_w12 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_a(a2), .in_b(b2),
    .out_valid(ov2), .out_ready(out_ready), .out_prod(p2w), .busy(bz2));

  assign p2 = p2w[15:0];

  always_comb begin
    s_ir = ir0; s_ov = ov0; s_bz = bz0; s_prod = {8'h00, p0};
    case (cur)
      1: begin s_ir = ir1; s_ov = ov1; s_bz = bz1; s_prod = {8'h00, p1}; end
      2: begin s_ir = ir2; s_ov = ov2; s_bz = bz2; s_prod = p2w; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected RUN cycles from accept to out_valid.
  function automatic int lat_of(input logic [11:0] a, input int wa);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int n = 0;
    for (int i = 0; i < wa; i++) if (a[i]) n = i + 1;
    return (n + 1 < wa) ? n + 1 : wa;
`else
    return wa;
`endif
  endfunction

  // Called #1 after an edge with the selected DUT idle.
  task automatic mult(input int sel, input logic [11:0] a, input logic [7:0] b,
                      input logic [23:0] exp, input int exp_lat, input string tag);
    int lat;
    cur = sel;
    a0 = a[7:0]; a1 = a[7:0]; a2 = a;
    b0 = b;      b1 = b;      b2 = b[3:0];
    iv0 = (sel == 0); iv1 = (sel == 1); iv2 = (sel == 2);
    @(posedge clk); #1;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    check({tag, "_busy"}, 32'(s_bz), 32'd1);
    lat = 0;
    while (!s_ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_prod"}, 32'(s_prod), 32'(exp));
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_idle"}, 32'(s_ir), 32'd1);
    end
  endtask

  initial begin
    logic [11:0] ra;
    logic [3:0]  rb;
    logic [23:0] rexp;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ir0), 32'd1);
    check("rst_out_valid", 32'(ov0), 32'd0);
    check("rst_busy", 32'(bz0), 32'd0);
    check("rst_prod", 32'(p0), 32'd0);
    rst = 1'b0;

    mult(0, 12'd255, 8'd255, 24'h00FE01, lat_of(12'd255, 8), "u_255x255");
    mult(0, 12'd0, 8'd200, 24'h000000, lat_of(12'd0, 8), "u_0x200");
    mult(0, 12'd1, 8'd200, 24'd200, lat_of(12'd1, 8), "u_1x200");
    mult(0, 12'd13, 8'd11, 24'd143, lat_of(12'd13, 8), "u_13x11");

    mult(1, 12'h0FF, 8'd127, 24'h00FF81, lat_of(12'h0FF, 8), "s_m1x127");
    mult(1, 12'h080, 8'h80, 24'h004000, lat_of(12'h080, 8), "s_m128xm128");
    mult(1, 12'd3, 8'hFB, 24'h00FFF1, lat_of(12'd3, 8), "s_3xm5");
    mult(1, 12'h07F, 8'h80, 24'h00C080, lat_of(12'h07F, 8), "s_127xm128");

    // Backpressure: DONE is held, new operands ignored.
    out_ready = 1'b0;
    mult(0, 12'd200, 8'd100, 24'h004E20, lat_of(12'd200, 8), "bp");
    for (int i = 0; i < 5; i++) begin
      iv0 = 1'b1; a0 = 8'd7; b0 = 8'd9;
      @(posedge clk); #1;
      check("bp_prod", 32'(p0), 32'h4E20);
      check("bp_in_ready", 32'(ir0), 32'd0);
      check("bp_out_valid", 32'(ov0), 32'd1);
    end
    iv0 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_in_ready", 32'(ir0), 32'd1);
    check("bp_rel_out_valid", 32'(ov0), 32'd0);

    // Reset with count==3 in RUN.
    a0 = 8'd200; b0 = 8'd100; iv0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mr_in_ready", 32'(ir0), 32'd1);
    check("mr_out_valid", 32'(ov0), 32'd0);
    check("mr_busy", 32'(bz0), 32'd0);
    check("mr_prod", 32'(p0), 32'd0);
    rst = 1'b0;
    mult(0, 12'd3, 8'd5, 24'd15, lat_of(12'd3, 8), "mr_3x5");

    mult(2, 12'd4095, 8'd15, 24'h00EFF1, lat_of(12'd4095, 12), "w_4095x15");
    for (int i = 0; i < 1000; i++) begin
      ra = 12'($urandom_range(0, 4095));
      rb = 4'($urandom_range(0, 15));
      rexp = 24'(ra) * 24'(rb);
      mult(2, ra, {4'h0, rb}, rexp, lat_of(ra, 12), "w_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
